// File: rtl/imhotep_pkg.sv
// Shared core package: data-memory controller types, access-width encodings and sizing helpers.
package imhotep_pkg;

   localparam int XLEN             = 32;
   localparam int RAM_WIDTH        = 32;
   localparam int DMEM_DEPTH_WORDS = 1024;

   localparam logic [1:0] MEM_W_BYTE = 2'b00;
   localparam logic [1:0] MEM_W_HALF = 2'b01;
   localparam logic [1:0] MEM_W_WORD = 2'b10;

   typedef enum logic [2:0] {
      DMEM_IDLE,
      DMEM_BEAT0,
      DMEM_BEAT1,
      DMEM_RESP,
      DMEM_ERR
   } dmem_state_e;

   function automatic logic [2:0] mem_size(input logic [1:0] w);
      case (w)
         MEM_W_BYTE: return 3'd1;
         MEM_W_HALF: return 3'd2;
         default:    return 3'd4;
      endcase
   endfunction

   function automatic logic [3:0] mem_mask(input logic [1:0] w);
      case (w)
         MEM_W_BYTE: return 4'b0001;
         MEM_W_HALF: return 4'b0011;
         default:    return 4'b1111;
      endcase
   endfunction

   function automatic logic mem_cross(input logic [1:0] off, input logic [1:0] w);
      return ({1'b0, off} + mem_size(w)) > 3'd4;
   endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// LSU <-> data-memory controller request/response bundle.
interface dmem_ctrl_if import imhotep_pkg::*; #(
   parameter int ADDR_W = RAM_WIDTH
);
   logic              req_i;
   logic [ADDR_W-1:0] addr_i;
   logic [XLEN-1:0]   data_i;
   logic [1:0]        width_i;
   logic              w_rn_i;
   logic              ready_o;
   logic              rvalid_o;
   logic [XLEN-1:0]   data_o;
   logic              error_o;

   modport master (
      output req_i, addr_i, data_i, width_i, w_rn_i,
      input  ready_o, rvalid_o, data_o, error_o
   );

   modport slave (
      input  req_i, addr_i, data_i, width_i, w_rn_i,
      output ready_o, rvalid_o, data_o, error_o
   );
endinterface

// File: rtl/dmem_sram.sv
// Single-port word SRAM with byte enables; read data registered, valid the cycle after the address.
module dmem_sram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk_i,
   input  logic          en_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);
   logic [3:0][7:0] mem_q [DEPTH_WORDS];
   logic [31:0]     rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            for (int b = 0; b < 4; b++) begin
               if (be_i[b]) mem_q[addr_i][b] <= wdata_i[8*b +: 8];
            end
         end
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte/half/word accesses onto a word SRAM, word-crossing accesses split
// into two beats when DMEM_MISALIGN_SPLIT_EN is defined, otherwise reported as errors.
module dmem_ctrl import imhotep_pkg::*; #(
   parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
   parameter int ADDR_W      = RAM_WIDTH
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   dmem_ctrl_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
`ifdef DMEM_MISALIGN_SPLIT_EN
   localparam int SPAN = 2;
`else
   localparam int SPAN = 1;
`endif

   dmem_state_e          state_q, state_d;
   logic [AW-1:0]        word_q;
   logic [1:0]           off_q, width_q;
   logic [XLEN-1:0]      wdat_q, dout_q, dout_d;
   logic                 wr_q, accept;
   logic                 sram_en, sram_we;
   logic [3:0]           sram_be;
   logic [AW-1:0]        sram_addr;
   logic [31:0]          sram_wdata, sram_rdata;
   logic [4*SPAN-1:0]    be_wide;
   logic [32*SPAN-1:0]   wd_wide;
   logic [XLEN-1:0]      rd_aligned, rd_mask;

   assign accept  = bus.req_i & bus.ready_o;
   // Lanes for both beats in one shift; the upper half belongs to the next word.
   assign be_wide = (4*SPAN)'(mem_mask(width_q)) << off_q;
   assign wd_wide = (32*SPAN)'(wdat_q) << {off_q, 3'b000};

`ifdef DMEM_MISALIGN_SPLIT_EN
   logic                cross_q;
   logic [XLEN-1:0]     hold_q;
   logic [2*XLEN-1:0]   rd_pair;

   assign cross_q    = mem_cross(off_q, width_q);
   assign rd_pair    = cross_q ? {sram_rdata, hold_q} : {32'b0, sram_rdata};
   assign rd_aligned = XLEN'(rd_pair >> {off_q, 3'b000});

   always_ff @(posedge clk_i) begin
      if (state_q == DMEM_BEAT1) hold_q <= sram_rdata;
   end
`else
   assign rd_aligned = sram_rdata >> {off_q, 3'b000};
`endif

   assign rd_mask = (width_q == MEM_W_BYTE) ? XLEN'(32'h0000_00ff) :
                    (width_q == MEM_W_HALF) ? XLEN'(32'h0000_ffff) : '1;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= DMEM_IDLE;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         dout_q  <= dout_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         word_q  <= bus.addr_i[2 +: AW];
         off_q   <= bus.addr_i[1:0];
         wdat_q  <= bus.data_i;
         width_q <= bus.width_i;
         wr_q    <= bus.w_rn_i;
      end
   end

   always_comb begin
      state_d    = state_q;
      dout_d     = dout_q;
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_be    = be_wide[3:0];
      sram_addr  = word_q;
      sram_wdata = wd_wide[31:0];
      case (state_q)
         DMEM_IDLE: begin
            if (accept) begin
               if (bus.width_i == 2'b11) state_d = DMEM_ERR;
`ifndef DMEM_MISALIGN_SPLIT_EN
               else if (mem_cross(bus.addr_i[1:0], bus.width_i)) state_d = DMEM_ERR;
`endif
               else state_d = DMEM_BEAT0;
            end
         end
         DMEM_BEAT0: begin
            sram_en = 1'b1;
            sram_we = wr_q & rst_ni;
            state_d = wr_q ? DMEM_IDLE : DMEM_RESP;
`ifdef DMEM_MISALIGN_SPLIT_EN
            if (cross_q) state_d = DMEM_BEAT1;
`endif
         end
`ifdef DMEM_MISALIGN_SPLIT_EN
         DMEM_BEAT1: begin
            sram_en    = 1'b1;
            sram_we    = wr_q & rst_ni;
            sram_addr  = word_q + AW'(1);
            sram_be    = be_wide[7:4];
            sram_wdata = wd_wide[63:32];
            state_d    = wr_q ? DMEM_IDLE : DMEM_RESP;
         end
`endif
         DMEM_RESP: begin
            dout_d  = rd_aligned & rd_mask;
            state_d = DMEM_IDLE;
         end
         default: state_d = DMEM_IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is held, even mid-operation.
   assign bus.ready_o  = (state_q == DMEM_IDLE) & rst_ni;
   assign bus.rvalid_o = (state_q == DMEM_RESP) & rst_ni;
   assign bus.error_o  = (state_q == DMEM_ERR) & rst_ni;
   assign bus.data_o   = rst_ni ? dout_d : '0;

   dmem_sram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_sram (
      .clk_i   (clk_i),
      .en_i    (sram_en),
      .we_i    (sram_we),
      .be_i    (sram_be),
      .addr_i  (sram_addr),
      .wdata_i (sram_wdata),
      .rdata_o (sram_rdata)
   );
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: byte-array memory model plus per-cycle expected-event schedule; honours DMEM_MISALIGN_SPLIT_EN.
module tb_dmem_ctrl;
   import imhotep_pkg::*;

   localparam int DEPTH = 1024;
   localparam int NB    = DEPTH * 4;
`ifdef DMEM_MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   dmem_ctrl_if #(.ADDR_W(RAM_WIDTH)) bus ();

   dmem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(RAM_WIDTH)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem [NB];
   int          cyc     = 0;
   int          n_chk   = 0;
   int          n_fail  = 0;
   int          rv_cyc  = -1;
   int          err_cyc = -1;
   int          rdy_cyc = 1 << 30;
   logic [31:0] rv_data = '0;
   logic [31:0] held    = '0;
   logic [31:0] last_rd = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int msize(input logic [1:0] w);
      return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] w);
      logic [31:0] v = '0;
      for (int i = 0; i < msize(w); i++)
         v[8*i +: 8] = mem[int'((a + 32'(i)) & 32'(NB-1))];
      return v;
   endfunction

   // Compare process: every cycle, outputs must match the schedule set up when the request was issued.
   always @(posedge clk) begin
      logic        e_rv, e_err, e_rdy;
      logic [31:0] e_do;
      cyc = cyc + 1;
      #1;
      e_rv  = rst_n && (cyc == rv_cyc);
      e_err = rst_n && (cyc == err_cyc);
      e_rdy = rst_n && (cyc >= rdy_cyc);
      if (!rst_n) held = '0;
      e_do  = !rst_n ? 32'h0 : (e_rv ? rv_data : held);
      chk("ready_o", 32'(bus.ready_o), 32'(e_rdy));
      chk("rvalid_o", 32'(bus.rvalid_o), 32'(e_rv));
      chk("error_o", 32'(bus.error_o), 32'(e_err));
      chk("data_o", bus.data_o, e_do);
      if (e_rv) begin
         held    = rv_data;
         last_rd = bus.data_o;
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                        input logic wr, input bit junk);
      int t, s;
      bit cr;
      while (cyc < rdy_cyc) begin
         bus.req_i   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.addr_i  = $urandom;
         bus.data_i  = $urandom;
         bus.width_i = 2'($urandom_range(0, 3));
         bus.w_rn_i  = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      bus.req_i = 1'b1; bus.addr_i = a; bus.data_i = d; bus.width_i = w; bus.w_rn_i = wr;
      t  = cyc;
      s  = msize(w);
      cr = (int'(a[1:0]) + s) > 4;
      if (w == 2'b11 || (cr && !SPLIT)) begin
         err_cyc = t + 1;
         rdy_cyc = t + 2;
      end else if (wr) begin
         for (int i = 0; i < s; i++) mem[int'((a + 32'(i)) & 32'(NB-1))] = d[8*i +: 8];
         rdy_cyc = t + 2 + int'(cr);
      end else begin
         rv_data = model_read(a, w);
         rv_cyc  = t + 2 + int'(cr);
         rdy_cyc = rv_cyc + 1;
      end
      @(negedge clk);
      bus.req_i = 1'b0;
   endtask

   task automatic wait_done();
      while (cyc < rdy_cyc) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      rst_n   = 1'b0;
      rv_cyc  = -1;
      err_cyc = -1;
      repeat (n) @(negedge clk);
      rst_n   = 1'b1;
      rdy_cyc = cyc + 1;
   endtask

   initial begin
      bus.req_i = 1'b0; bus.addr_i = '0; bus.data_i = '0; bus.width_i = 2'b00; bus.w_rn_i = 1'b0;
      for (int i = 0; i < NB; i++) mem[i] = 8'h00;
      do_reset(2);

      for (int w = 0; w < DEPTH; w++) issue(32'(w * 4), 32'h0, MEM_W_WORD, 1'b1, 1'b0);

      issue(32'h10, 32'hDEADBEEF, MEM_W_WORD, 1'b1, 1'b0);
      issue(32'h10, 32'h0, MEM_W_WORD, 1'b0, 1'b0);
      wait_done();
      chk("lw_0x10", last_rd, 32'hDEADBEEF);

      issue(32'h13, 32'h000000AB, MEM_W_BYTE, 1'b1, 1'b0);
      issue(32'h11, 32'h00001234, MEM_W_HALF, 1'b1, 1'b0);
      chk("model_0x10", model_read(32'h10, MEM_W_WORD), 32'hAB1234EF);
      issue(32'h10, 32'h0, MEM_W_WORD, 1'b0, 1'b0);
      wait_done();
      chk("lw_0x10_merged", last_rd, 32'hAB1234EF);
      issue(32'h13, 32'h0, MEM_W_BYTE, 1'b0, 1'b0);
      wait_done();
      chk("lbu_0x13", last_rd, 32'h000000AB);

      issue(32'h22, 32'h11223344, MEM_W_WORD, 1'b1, 1'b0);
      issue(32'h20, 32'h0, MEM_W_WORD, 1'b0, 1'b0);
      wait_done();
      chk("lw_0x20", last_rd, SPLIT ? 32'h33440000 : 32'h0);
      issue(32'h24, 32'h0, MEM_W_WORD, 1'b0, 1'b0);
      wait_done();
      chk("lw_0x24", last_rd, SPLIT ? 32'h00001122 : 32'h0);
      issue(32'h23, 32'h0, MEM_W_HALF, 1'b0, 1'b0);
      wait_done();
      chk("lh_0x23", last_rd, SPLIT ? 32'h00002233 : 32'h0);

      issue(32'hFFE, 32'hCAFEF00D, MEM_W_WORD, 1'b1, 1'b0);
      chk("model_wrap_top", model_read(32'hFFC, MEM_W_WORD), SPLIT ? 32'hF00D0000 : 32'h0);
      issue(32'hFFC, 32'h0, MEM_W_WORD, 1'b0, 1'b0);
      wait_done();
      chk("lw_0xffc", last_rd, SPLIT ? 32'hF00D0000 : 32'h0);
      issue(32'h0, 32'h0, MEM_W_WORD, 1'b0, 1'b0);
      wait_done();
      chk("lw_0x000", last_rd, SPLIT ? 32'h0000CAFE : 32'h0);

      issue(32'h10, 32'h55555555, 2'b11, 1'b1, 1'b0);
      issue(32'h10, 32'h0, 2'b11, 1'b0, 1'b0);
      issue(32'h10, 32'h0, MEM_W_WORD, 1'b0, 1'b0);
      wait_done();
      chk("lw_after_illegal", last_rd, 32'hAB1234EF);

      // Crossing load cut by reset in its second beat.
      issue(32'h22, 32'h0, MEM_W_WORD, 1'b0, 1'b0);
      @(negedge clk);
      do_reset(1);
      issue(32'h20, 32'h0, MEM_W_WORD, 1'b0, 1'b0);
      wait_done();
      chk("lw_after_reset", last_rd, SPLIT ? 32'h33440000 : 32'h0);

      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         logic [1:0]  w;
         int          r;
         a = $urandom;
         if ($urandom_range(0, 3) == 0) a[11:2] = 10'h3FF;
         r = $urandom_range(0, 9);
         w = (r < 3) ? MEM_W_BYTE : (r < 6) ? MEM_W_HALF : (r < 9) ? MEM_W_WORD : 2'b11;
         issue(a, $urandom, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_done();
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
